// File: rtl/bicubic_tap_mac.sv
// 4-tap bicubic MAC: outer taps subtracted, inner taps added, rounded, shifted, clamped.
// Optional clamp-event counter enabled by defining BICUBIC_MAC_SATCNT_EN.
module bicubic_tap_mac #(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned W_W       = 9,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] pix0,
  input  logic [PIX_W-1:0] pix1,
  input  logic [PIX_W-1:0] pix2,
  input  logic [PIX_W-1:0] pix3,
  input  logic [W_W-1:0]   w0,
  input  logic [W_W-1:0]   w1,
  input  logic [W_W-1:0]   w2,
  input  logic [W_W-1:0]   w3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_sof
`ifdef BICUBIC_MAC_SATCNT_EN
  ,
  output logic [15:0]      sat_cnt
`endif
);

  localparam int unsigned PW = PIX_W + W_W;
  localparam int unsigned AW = PW + 2;
  localparam logic [AW-1:0] Rnd = AW'(2 ** (FRAC_BITS - 1));

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: unsigned tap products
  logic          s1_valid_q, s1_sof_q;
  logic [PW-1:0] prod0_q, prod1_q, prod2_q, prod3_q;
  logic [PW-1:0] prod0_d, prod1_d, prod2_d, prod3_d;

  always_comb begin
    prod0_d = PW'(pix0) * PW'(w0);
    prod1_d = PW'(pix1) * PW'(w1);
    prod2_d = PW'(pix2) * PW'(w2);
    prod3_d = PW'(pix3) * PW'(w3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      prod0_q    <= '0;
      prod1_q    <= '0;
      prod2_q    <= '0;
      prod3_q    <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_sof_q   <= in_sof;
      prod0_q    <= prod0_d;
      prod1_q    <= prod1_d;
      prod2_q    <= prod2_d;
      prod3_q    <= prod3_d;
    end
  end

  // S2: signed accumulate; modular unsigned math yields the correct two's complement
  logic                 s2_valid_q, s2_sof_q;
  logic signed [AW-1:0] acc_q, acc_d;
  logic        [AW-1:0] sum_pos, sum_neg;

  always_comb begin
    sum_pos = {2'b00, prod1_q} + {2'b00, prod2_q};
    sum_neg = {2'b00, prod0_q} + {2'b00, prod3_q};
    acc_d   = $signed(sum_pos - sum_neg + Rnd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sof_q   <= 1'b0;
      acc_q      <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_sof_q   <= s1_sof_q;
      acc_q      <= acc_d;
    end
  end

  // S3: shift and clamp
  logic signed [AW-1:0] r;
  logic [PIX_W-1:0]     pix_d;

  always_comb begin
    r = acc_q >>> FRAC_BITS;
    if (r[AW-1]) begin
      pix_d = '0;
    end else if (|r[AW-2:PIX_W]) begin
      pix_d = '1;
    end else begin
      pix_d = r[PIX_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_pix   <= '0;
    end else if (adv) begin
      out_valid <= s2_valid_q;
      out_sof   <= s2_sof_q;
      out_pix   <= pix_d;
    end
  end

`ifdef BICUBIC_MAC_SATCNT_EN
  logic clamp_d, clamp_q;
  assign clamp_d = r[AW-1] | (|r[AW-2:PIX_W]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clamp_q <= 1'b0;
    end else if (adv) begin
      clamp_q <= clamp_d;
    end
  end

  // A start-of-frame accept clears the count even if an older clamped beat leaves this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (in_valid && in_ready && in_sof) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && clamp_q && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bicubic_tap_mac.sv
// Directed bench for bicubic_tap_mac: latency, clamping, rounding, backpressure, reset.
// Counter checks are active when BICUBIC_MAC_SATCNT_EN is defined.
module tb_bicubic_tap_mac;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_sof;
  logic [7:0] pix0, pix1, pix2, pix3;
  logic [8:0] w0, w1, w2, w3;
  logic       out_valid, out_ready, out_sof;
  logic [7:0] out_pix;
`ifdef BICUBIC_MAC_SATCNT_EN
  logic [15:0] sat_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bicubic_tap_mac dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sof   (in_sof),
    .pix0     (pix0),
    .pix1     (pix1),
    .pix2     (pix2),
    .pix3     (pix3),
    .w0       (w0),
    .w1       (w1),
    .w2       (w2),
    .w3       (w3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pix  (out_pix),
    .out_sof  (out_sof)
`ifdef BICUBIC_MAC_SATCNT_EN
    ,
    .sat_cnt  (sat_cnt)
`endif
  );

  // Hand-computed vectors: 0 identity, 2 overshoot, 3 undershoot, 5/6 rounding edge
  int vp [8][4] = '{'{0, 100, 0, 0}, '{10, 20, 30, 40}, '{0, 255, 255, 0}, '{255, 0, 0, 255},
                    '{100, 100, 100, 100}, '{0, 1, 0, 0}, '{0, 1, 0, 0}, '{200, 60, 80, 10}};
  int vw [8][4] = '{'{0, 256, 0, 0}, '{0, 128, 128, 0}, '{0, 256, 256, 0}, '{32, 224, 224, 32},
                    '{16, 144, 144, 16}, '{0, 128, 0, 0}, '{0, 127, 0, 0}, '{20, 200, 100, 30}};
  int vexp [8] = '{100, 25, 255, 0, 100, 1, 0, 61};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply(input int i, input logic sof);
    pix0 = 8'(vp[i][0]); pix1 = 8'(vp[i][1]); pix2 = 8'(vp[i][2]); pix3 = 8'(vp[i][3]);
    w0 = 9'(vw[i][0]); w1 = 9'(vw[i][1]); w2 = 9'(vw[i][2]); w3 = 9'(vw[i][3]);
    in_sof = sof;
  endtask

  // Starts and ends #1 after a rising edge, with out_ready=1
  task automatic single(input int i, input logic sof, input string tag);
    apply(i, sof);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_early"}, 32'(out_valid), 0);
    @(posedge clk); #1;
    check_eq({tag, "_valid"}, 32'(out_valid), 1);
    check_eq({tag, "_pix"}, 32'(out_pix), 32'(vexp[i]));
    check_eq({tag, "_sof"}, 32'(out_sof), 32'(sof));
    @(posedge clk); #1;
    check_eq({tag, "_drained"}, 32'(out_valid), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    apply(0, 1'b0);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_pix", 32'(out_pix), 0);
    check_eq("rst_out_sof", 32'(out_sof), 0);
    check_eq("rst_in_ready", 32'(in_ready), 1);
`ifdef BICUBIC_MAC_SATCNT_EN
    check_eq("rst_sat_cnt", 32'(sat_cnt), 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    single(0, 1'b1, "ident");
`ifdef BICUBIC_MAC_SATCNT_EN
    check_eq("sat_after_ident", 32'(sat_cnt), 0);
`endif
    single(2, 1'b0, "over");
`ifdef BICUBIC_MAC_SATCNT_EN
    check_eq("sat_after_over", 32'(sat_cnt), 1);
`endif
    single(3, 1'b0, "under");
`ifdef BICUBIC_MAC_SATCNT_EN
    check_eq("sat_after_under", 32'(sat_cnt), 2);
`endif
    single(5, 1'b0, "rnd_up");
    single(6, 1'b0, "rnd_dn");
`ifdef BICUBIC_MAC_SATCNT_EN
    check_eq("sat_after_rnd", 32'(sat_cnt), 2);
`endif

    // Backpressure: 8 back-to-back beats, out_ready low for cycles 4..9
    begin
      int mi;
      mi = 0;
      fork
        begin
          int di;
          logic taken;
          di = 0;
          while (di < 8) begin
            apply(di, di == 0);
            in_valid = 1'b1;
            @(negedge clk);
            taken = in_ready;
            @(posedge clk); #1;
            if (taken) di++;
          end
          in_valid = 1'b0;
        end
        begin
          for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 4 && c <= 9);
            @(posedge clk); #1;
          end
        end
        begin
          for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid && !out_ready) check_eq("bp_in_ready_low", 32'(in_ready), 0);
            if (out_valid && out_ready) begin
              if (mi < 8) begin
                check_eq($sformatf("bp_pix%0d", mi), 32'(out_pix), 32'(vexp[mi]));
                check_eq($sformatf("bp_sof%0d", mi), 32'(out_sof), 32'(mi == 0));
              end
              mi++;
            end
          end
        end
      join
      check_eq("bp_count", 32'(mi), 8);
    end
`ifdef BICUBIC_MAC_SATCNT_EN
    check_eq("bp_sat_cnt", 32'(sat_cnt), 2);
`endif

    // Clamped beat leaves on the same edge a start-of-frame beat is accepted
    out_ready = 1'b1;
    apply(2, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check_eq("clr_pre_valid", 32'(out_valid), 1);
    apply(0, 1'b1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef BICUBIC_MAC_SATCNT_EN
    check_eq("clr_wins", 32'(sat_cnt), 0);
`endif
    repeat (4) begin @(posedge clk); #1; end
`ifdef BICUBIC_MAC_SATCNT_EN
    check_eq("clr_after", 32'(sat_cnt), 0);
`endif

    // Reset with three beats in flight
    for (int k = 2; k < 5; k++) begin
      apply(k, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    check_eq("mid_pre_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 0);
    check_eq("mid_rst_pix", 32'(out_pix), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_eq("mid_no_ghost", 32'(out_valid), 0);
    single(2, 1'b1, "post_rst");
`ifdef BICUBIC_MAC_SATCNT_EN
    check_eq("post_rst_sat", 32'(sat_cnt), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
